display_scanner: RTL and testbench

//  Consumer side of the display clock path: takes a one-cycle scan_tick from the clock divider.

---
 rtl/display_pkg.sv | 23 ++
 rtl/hex_to_seg.sv | 9 +
 rtl/display_scanner.sv | 99 +++++++++
 tb/tb_display_scanner.sv | 135 +++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared glyph constants and scanner state type for the 7-segment display path.
package display_pkg;
  typedef enum logic {BLANK, SHOW} state_t;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low {g,f,e,d,c,b,a} glyph.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/display_scanner.sv
// display_scanner: multiplexed common-anode hex display with frame-aligned commit and anti-ghost blanking.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module display_scanner
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_tick,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic                  busy,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  state_t                state, state_nxt;
  logic [BW-1:0]         blank_cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [4*N_DIGITS-1:0] pending, active;
  logic [N_DIGITS-1:0]   pending_dp, active_dp, an_nxt;
  logic [6:0]            seg_nxt, digit_seg;
  logic                  dp_nxt, wrap, commit, lead_zero;
  hex_to_seg u_dec (.hex(active[{idx, 2'b00} +: 4]), .seg(digit_seg));
`ifdef LEADING_ZERO_BLANK_EN
  assign lead_zero = (idx != '0) && ((active >> {idx, 2'b00}) == '0);
`else
  assign lead_zero = 1'b0;
`endif
  assign wrap   = idx == IW'(N_DIGITS - 1);
  assign commit = (state == SHOW) && scan_tick && wrap;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = blank_cnt;
    idx_nxt   = idx;
    an_nxt    = '1;
    seg_nxt   = SEG_OFF;
    dp_nxt    = 1'b1;
    if (state == BLANK) begin
      cnt_nxt = blank_cnt + BW'(1);
      if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
        state_nxt = SHOW;
        an_nxt    = ~(N_DIGITS'(1) << idx);
        seg_nxt   = lead_zero ? SEG_OFF : digit_seg;
        dp_nxt    = ~active_dp[idx];
      end
    end else if (scan_tick) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      idx_nxt   = wrap ? '0 : idx + IW'(1);
    end else begin
      an_nxt  = an;
      seg_nxt = seg;
      dp_nxt  = dp;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BLANK;
      blank_cnt <= '0;
      idx       <= '0;
      an        <= '1;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      state     <= state_nxt;
      blank_cnt <= cnt_nxt;
      idx       <= idx_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      dp        <= dp_nxt;
    end
  end
  // commit samples the old pending, so a coincident load lands in the next frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      pending_dp <= '0;
      active     <= '0;
      active_dp  <= '0;
      busy       <= 1'b0;
    end else begin
      if (load) begin
        pending    <= data_in;
        pending_dp <= dp_in;
      end
      if (commit) begin
        active    <= pending;
        active_dp <= pending_dp;
      end
      busy <= load | (busy & ~commit);
    end
  end
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed plus randomized checks of display_scanner against a frame-level model.
module tb_display_scanner;
  logic        clk = 1'b0;
  logic        rst, scan_tick, load, busy, dp;
  logic [15:0] data_in;
  logic [3:0]  dp_in, an;
  logic [6:0]  seg;
  int          n_chk = 0, n_fail = 0;
  int          m_idx;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pend_dp, m_act_dp;
  logic        m_busy;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  display_scanner dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .load(load), .data_in(data_in),
    .dp_in(dp_in), .busy(busy), .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0) return 7'h7F;
`endif
    return GLYPH[(v >> (4 * d)) & 16'hF];
  endfunction
  task automatic chk_show();
    logic [3:0] e_an;
    logic       e_dp;
    e_an = ~(4'b0001 << m_idx);
    e_dp = ~m_act_dp[m_idx];
    chk("show_an", an, e_an);
    chk("show_seg", seg, exp_seg(m_act, m_idx));
    chk("show_dp", dp, e_dp);
    chk("show_busy", busy, m_busy);
  endtask
  task automatic model_reset();
    m_idx = 0; m_pend = '0; m_act = '0; m_pend_dp = '0; m_act_dp = '0; m_busy = 1'b0;
  endtask
  task automatic after_reset();
    repeat (15) @(negedge clk);
    chk("rst_blank_len", an, 4'hF);
    @(negedge clk);
    chk_show();
  endtask
  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; data_in = d; dp_in = p;
    @(negedge clk);
    load = 1'b0;
    m_pend = d; m_pend_dp = p; m_busy = 1'b1;
    chk_show();
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n > 0) chk_show();
  endtask
  // sp selects a stray scan_tick inside the blank interval (-1: none); it must be ignored
  task automatic do_tick(input bit ld, input logic [15:0] d, input logic [3:0] p, input int sp);
    scan_tick = 1'b1; load = ld; data_in = d; dp_in = p;
    @(negedge clk);
    scan_tick = 1'b0; load = 1'b0;
    if (m_idx == 3) begin
      m_act = m_pend; m_act_dp = m_pend_dp; m_busy = 1'b0;
    end
    if (ld) begin
      m_pend = d; m_pend_dp = p; m_busy = 1'b1;
    end
    m_idx = (m_idx + 1) % 4;
    chk("blank_an", an, 4'hF);
    chk("blank_seg", seg, 7'h7F);
    chk("blank_busy", busy, m_busy);
    for (int k = 0; k < 15; k++) begin
      scan_tick = (k == sp);
      @(negedge clk);
      scan_tick = 1'b0;
    end
    chk("blank_len", an, 4'hF);
    scan_tick = (sp == 15);
    @(negedge clk);
    scan_tick = 1'b0;
    chk_show();
  endtask
  initial begin
    rst = 1'b0; scan_tick = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b1;
    after_reset();
    do_load(16'h1234, 4'h0);
    idle(30);
    for (int i = 0; i < 8; i++) do_tick(1'b0, '0, '0, (i == 2) ? 15 : -1);
    do_load(16'h1111, 4'h3);
    idle(5);
    do_tick(1'b0, '0, '0, -1);
    do_load(16'h8888, 4'h9);
    for (int i = 0; i < 6; i++) do_tick(1'b0, '0, '0, -1);
    do_load(16'h4321, 4'h1);
    while (m_idx != 3) do_tick(1'b0, '0, '0, -1);
    do_tick(1'b1, 16'hABCD, 4'h8, -1);
    for (int i = 0; i < 8; i++) do_tick(1'b0, '0, '0, -1);
    do_load(16'h0070, 4'h5);
    for (int i = 0; i < 8; i++) do_tick(1'b0, '0, '0, -1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) do_load(16'($urandom), 4'($urandom));
      idle($urandom_range(0, 8));
      do_tick($urandom_range(0, 4) == 0, 16'($urandom), 4'($urandom),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1);
    end
    do_load(16'hFFFF, 4'hF);
    idle(3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp", dp, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    after_reset();
    for (int i = 0; i < 4; i++) do_tick(1'b0, '0, '0, -1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
